// File: rtl/ext_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ext_io_bridge_pkg
// Purpose  : Shared FSM state type and IO direction encodings for the bridge.
// Revision : 1.0 - initial release
// ============================================================================
package ext_io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic IO_RW_READ  = 1'b1;
  localparam logic IO_RW_WRITE = 1'b0;

endpackage : ext_io_bridge_pkg
`default_nettype wire

// File: rtl/ext_io_sync.sv
`default_nettype none
// ============================================================================
// Module   : ext_io_sync
// Purpose  : Two-flop synchroniser for a single asynchronous level input.
// Revision : 1.0 - initial release
// ============================================================================
module ext_io_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : ext_io_sync
`default_nettype wire

// File: rtl/ext_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ext_io_bridge
// Purpose  : Avalon-MM slave to acknowledge-handshaked external IO bus bridge.
//            Optional acknowledge timeout enabled by EXT_IO_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ext_io_bridge
  import ext_io_bridge_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_waitrequest,
  output logic [ADDR_W-1:0]   io_address,
  output logic                io_bus_enable,
  output logic [DATA_W/8-1:0] io_byte_enable,
  output logic                io_rw,
  output logic [DATA_W-1:0]   io_write_data,
  input  logic [DATA_W-1:0]   io_read_data,
  input  logic                io_acknowledge,
  input  logic                io_irq,
  output logic                irq,
  output logic                timeout_err,
  input  logic                err_clr
);

  bridge_state_t r_state;
  bridge_state_t w_next_state;

  logic [ADDR_W-1:0]   r_io_address;
  logic [DATA_W/8-1:0] r_io_byte_enable;
  logic [DATA_W-1:0]   r_io_write_data;
  logic                r_io_rw;
  logic [DATA_W-1:0]   r_readdata;

  logic w_cmd;
  logic w_expire;

  assign w_cmd = avs_read | avs_write;

`ifdef EXT_IO_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_bus_cnt;
  logic             r_timeout_err;

  // Counter holds the number of completed BUS cycles; expiry fires during the
  // TIMEOUT_CYC-th BUS cycle unless acknowledge arrives in that same cycle.
  assign w_expire = (r_state == BUS) && !io_acknowledge &&
                    (r_bus_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bus_cnt <= '0;
    end else if (r_state == BUS) begin
      r_bus_cnt <= r_bus_cnt + 1'b1;
    end else begin
      r_bus_cnt <= '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_expire) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  localparam logic [31:0] C_TIMEOUT_CYC = TIMEOUT_CYC;

  logic w_unused_cfg;

  assign w_expire     = 1'b0;
  assign timeout_err  = 1'b0;
  assign w_unused_cfg = err_clr ^ C_TIMEOUT_CYC[0];
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cmd) w_next_state = BUS;
      BUS:     if (io_acknowledge || w_expire) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    io_bus_enable   = 1'b0;
    avs_waitrequest = 1'b1;
    case (r_state)
      BUS:     io_bus_enable   = 1'b1;
      DONE:    avs_waitrequest = 1'b0;
      default: ;
    endcase
  end

  // A read takes priority when both commands are presented together.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_io_address     <= '0;
      r_io_byte_enable <= '0;
      r_io_write_data  <= '0;
      r_io_rw          <= IO_RW_READ;
      r_readdata       <= '0;
    end else begin
      if ((r_state == IDLE) && w_cmd) begin
        r_io_address     <= avs_address;
        r_io_byte_enable <= avs_byteenable;
        r_io_write_data  <= avs_writedata;
        r_io_rw          <= avs_read ? IO_RW_READ : IO_RW_WRITE;
      end
      if ((r_state == BUS) && (r_io_rw == IO_RW_READ)) begin
        if (io_acknowledge) begin
          r_readdata <= io_read_data;
        end else if (w_expire) begin
          r_readdata <= '1;
        end
      end
    end
  end

  assign io_address     = r_io_address;
  assign io_byte_enable = r_io_byte_enable;
  assign io_write_data  = r_io_write_data;
  assign io_rw          = r_io_rw;
  assign avs_readdata   = r_readdata;

  ext_io_sync u_irq_sync (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_async (io_irq),
    .o_sync  (irq)
  );

endmodule : ext_io_bridge
`default_nettype wire

// File: doc/ext_io_bridge.md
EXT_IO_BRIDGE -- requirements
Module: ext_io_bridge

Interface
REQ-001 Parameter DATA_W, default 16: IO data width; legal values 16 or 32.
REQ-002 Parameter ADDR_W, default 16: IO word-address width.
REQ-003 Parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for an acknowledge.
REQ-004 Port clk_clk, input, 1: single clock; all logic rising-edge.
REQ-005 Port reset_reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port avs_address, input, ADDR_W: Avalon-MM word address.
REQ-007 Ports avs_read and avs_write, input, 1 each: Avalon-MM commands.
REQ-008 Port avs_writedata, input, DATA_W: write data.
REQ-009 Port avs_byteenable, input, DATA_W/8: byte lanes.
REQ-010 Port avs_readdata, output, DATA_W: read data.
REQ-011 Port avs_waitrequest, output, 1: high stalls the Avalon master.
REQ-012 Port io_address, output, ADDR_W: external bus address.
REQ-013 Port io_bus_enable, output, 1: external transfer request.
REQ-014 Port io_byte_enable, output, DATA_W/8: external byte lanes.
REQ-015 Port io_rw, output, 1: 1 = read, 0 = write.
REQ-016 Port io_write_data, output, DATA_W: external write data.
REQ-017 Port io_read_data, input, DATA_W: external read data.
REQ-018 Port io_acknowledge, input, 1: transfer complete, sampled synchronously.
REQ-019 Port io_irq, input, 1: asynchronous external interrupt.
REQ-020 Port irq, output, 1: synchronised interrupt to the CPU.
REQ-021 Port timeout_err, output, 1: sticky timeout flag.
REQ-022 Port err_clr, input, 1: clears timeout_err.

Function
REQ-023 FSM states SHALL be IDLE, BUS, DONE.
REQ-024 In IDLE with avs_read or avs_write high, the block SHALL latch address, data, byte enables and direction, then enter BUS on the next cycle.
REQ-025 With avs_read and avs_write both high, a read SHALL be performed and the write ignored.
REQ-026 In BUS, io_bus_enable SHALL be high and io_address, io_byte_enable, io_rw, io_write_data SHALL be stable from the latched values.
REQ-027 When io_acknowledge is sampled high in BUS, the block SHALL capture io_read_data (reads only) into avs_readdata and enter DONE.
REQ-028 In DONE, io_bus_enable SHALL be low and avs_waitrequest low for exactly one cycle; the FSM then returns to IDLE.
REQ-029 avs_waitrequest SHALL be high in every state except DONE.
REQ-030 Minimum latency from command to waitrequest low SHALL be 3 cycles, with acknowledge in the first BUS cycle.
REQ-031 io_acknowledge outside BUS SHALL be ignored.
REQ-032 irq SHALL equal io_irq delayed by a 2-flop synchroniser.
REQ-033 avs_readdata SHALL hold its value until the next completed read.

Reset
REQ-034 On reset assertion, the FSM SHALL enter IDLE asynchronously, including mid-transaction.
REQ-035 Reset values: io_bus_enable 0; io_address, io_byte_enable, io_write_data, avs_readdata 0; io_rw 1; avs_waitrequest 1; irq 0; timeout_err 0; synchroniser flops 0.

Configuration
REQ-036 Macro EXT_IO_BRIDGE_TIMEOUT_EN, when defined, SHALL enable a BUS-cycle counter. At TIMEOUT_CYC cycles without acknowledge, the block SHALL enter DONE with avs_readdata set to all ones (reads only) and set timeout_err.
REQ-037 With the macro defined, acknowledge in the same cycle as expiry SHALL win: normal completion, no error.
REQ-038 With the macro defined, err_clr SHALL clear timeout_err, and a simultaneous new timeout SHALL win.
REQ-039 Without the macro, BUS SHALL wait indefinitely, timeout_err SHALL be tied to 0, and err_clr SHALL be ignored.

Structure
REQ-040 Package ext_io_bridge_pkg SHALL hold the FSM state enum and the constants IO_RW_READ = 1 and IO_RW_WRITE = 0.
REQ-041 The 2-flop synchroniser SHALL be sub-module ext_io_sync, instantiated for io_irq.

Verification
REQ-042 Write: address 0x0010, data 0xBEEF, byteenable 2'b11, acknowledge after 2 BUS cycles -> io_rw 0, io_write_data 0xBEEF, one-cycle waitrequest low, io_bus_enable low in DONE.
REQ-043 Read: address 0x0020, io_read_data 0x1234, acknowledge in the first BUS cycle -> avs_readdata 0x1234, waitrequest low at cycle 3.
REQ-044 Timeout (macro defined, TIMEOUT_CYC=8): read, no acknowledge -> after 8 BUS cycles avs_readdata 0xFFFF and timeout_err 1; err_clr pulse -> 0.
REQ-045 Acknowledge in the expiry cycle (TIMEOUT_CYC=8) -> normal data returned, timeout_err stays 0.
REQ-046 Reset asserted in BUS -> io_bus_enable 0 and avs_waitrequest 1 immediately; after release, the next read completes normally.
REQ-047 io_irq rising edge -> irq high 2 clock edges later; DATA_W=32 read of 0xDEADBEEF -> returned intact.
